// File: rtl/rbs_serial.sv
// ---------------------------------------------------------------------------
// rbs_serial -- 4-bit bit-serial ripple-borrow subtractor.
//
// Computes D = {borrow_out, (a - b - Bin) mod 16}, one bit per clock,
// LSB first. An operation takes 4 SHIFT cycles followed by one DONE cycle.
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   load   in   1  start request; ignored while busy
//   a      in   4  minuend (unsigned)
//   b      in   4  subtrahend (unsigned)
//   Bin    in   1  borrow-in
//   busy   out  1  high while the subtraction is being shifted through
//   done   out  1  one-cycle pulse marking a new valid D
//   D      out  5  {borrow_out, difference[3:0]}; holds until next completion
// ---------------------------------------------------------------------------
module rbs_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Bin,
  output logic       busy,
  output logic       done,
  output logic [4:0] D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;

  logic [3:0] a_sh;     // operand a, consumed from bit 0
  logic [3:0] b_sh;     // operand b, consumed from bit 0
  logic [2:0] diff_sh;  // difference bits 0..2, filled from the top
  logic       brw;      // running borrow
  logic [1:0] cnt;      // index of the bit processed on the next SHIFT edge
  logic [4:0] d_q;

  logic       a_i, b_i, dbit, brw_next, last, start;

  // Single-bit full subtractor on the current LSBs.
  assign a_i      = a_sh[0];
  assign b_i      = b_sh[0];
  assign dbit     = a_i ^ b_i ^ brw;
  assign brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw);
  assign last     = (cnt == 2'd3);

  // A new operation can begin from IDLE or DONE, never mid-shift.
  assign start    = load && (state_q != SHIFT);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = load ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every datapath register, including the result, is cleared by the
  // async reset so an aborted operation leaves D reading zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      d_q     <= '0;
    end else if (start) begin
      a_sh    <= a;
      b_sh    <= b;
      diff_sh <= '0;
      brw     <= Bin;
      cnt     <= '0;
    end else if (state_q == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= {dbit, diff_sh[2:1]};
      brw     <= brw_next;
      cnt     <= cnt + 2'd1;
      // Bit 3 completes the word: publish result together with final borrow.
      if (last) d_q <= {brw_next, dbit, diff_sh};
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = d_q;

endmodule

// File: tb/tb_rbs_serial.sv
// ---------------------------------------------------------------------------
// tb_rbs_serial -- self-checking bench for rbs_serial.
// A behavioural model tracks each operation as "result computed with plain
// arithmetic, available after a fixed number of cycles"; a compare process
// checks busy/done/D against it on every falling edge. Directed cases pin
// literal results; an exhaustive sweep and a random phase follow.
// ---------------------------------------------------------------------------
module tb_rbs_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       Bin = 1'b0;
  logic       busy, done;
  logic [4:0] D;

  int total = 0;
  int bad   = 0;

  rbs_serial dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .a    (a),
    .b    (b),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .D    (D)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the subtraction definition.
  function automatic logic [4:0] ref_sub(input int ua, input int ub, input int ubin);
    int diff;
    diff = (ua - ub - ubin) & 15;
    return {logic'(ua < ub + ubin), 4'(diff)};
  endfunction

  // ---------------- behavioural model ----------------
  int         left = 0;      // SHIFT cycles still to go for the current op
  logic [4:0] pending = '0;  // result of the op in flight
  logic       m_done = 1'b0;
  logic [4:0] m_d = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = 0; pending = '0; m_done = 1'b0; m_d = '0;
    end else if (left > 0) begin
      left = left - 1;
      if (left == 0) begin
        m_d = pending;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (load) begin
        pending = ref_sub(int'(a), int'(b), int'(Bin));
        left = 4;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("busy", {4'b0, busy}, {4'b0, logic'(left > 0)});
    check("done", {4'b0, done}, {4'b0, m_done});
    check("D",    D,            m_d);
  end

  // ---------------- stimulus helpers ----------------
  // Waits for done; returns the number of falling edges observed since the
  // load edge (5 expected), or 99 if the bound expired.
  task automatic wait_done(output int cyc);
    cyc = 99;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // One full operation with load pulsed for a single cycle; inputs are
  // scrambled right after the load edge.
  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                        input logic [4:0] exp_d, input string name);
    int cyc;
    @(posedge clk); #2;
    load = 1'b1; a = va; b = vb; Bin = vbin;
    @(posedge clk); #2;
    load = 1'b0; a = 4'($urandom); b = 4'($urandom); Bin = 1'($urandom);
    wait_done(cyc);
    check({name, "_lat"}, 5'(cyc), 5'd5);
    check(name, D, exp_d);
  endtask

  int cyc, pulses;

  initial begin
    // Reset state
    #3;
    check("rst_busy", {4'b0, busy}, 5'd0);
    check("rst_done", {4'b0, done}, 5'd0);
    check("rst_D", D, 5'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Pin the reference arithmetic with hand-computed values.
    check("ref_0001_0101", ref_sub(1, 5, 0), 5'b11100);
    check("ref_0000_0000_1", ref_sub(0, 0, 1), 5'b11111);
    check("ref_1100_0100", ref_sub(12, 4, 0), 5'b01000);

    // Basic borrow, borrow-in underflow, no-borrow
    run_op(4'b0001, 4'b0101, 1'b0, 5'b11100, "basic");
    run_op(4'b0000, 4'b0000, 1'b1, 5'b11111, "bin_uflow");
    run_op(4'b1100, 4'b0100, 1'b0, 5'b01000, "no_borrow");

    // Back-to-back with load held through DONE
    @(posedge clk); #2;
    load = 1'b1; a = 4'b0111; b = 4'b0111; Bin = 1'b0;
    @(posedge clk); #2;
    a = 4'b1000; b = 4'b0111; Bin = 1'b1;   // ignored during SHIFT, taken in DONE
    wait_done(cyc);
    check("b2b1_lat", 5'(cyc), 5'd5);
    check("b2b1", D, 5'b00000);
    @(posedge clk); #2 load = 1'b0;
    @(negedge clk);
    check("b2b_no_idle", {4'b0, busy}, 5'd1);
    wait_done(cyc);
    check("b2b2_lat", 5'(cyc), 5'd4);
    check("b2b2", D, 5'b00000);

    // Load during SHIFT is ignored
    @(posedge clk); #2;
    load = 1'b1; a = 4'b1001; b = 4'b1010; Bin = 1'b1;
    @(posedge clk); #2 load = 1'b0;
    @(posedge clk); #2;
    load = 1'b1; a = 4'b1111; b = 4'b0000;
    @(posedge clk); #2 load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("ld_shift", D, 5'b11110);
      end
    end
    check("ld_shift_pulses", 5'(pulses), 5'd1);

    // Reset mid-operation
    @(posedge clk); #2;
    load = 1'b1; a = 4'b0001; b = 4'b0101; Bin = 1'b0;
    @(posedge clk); #2 load = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {4'b0, busy}, 5'd0);
    check("mid_rst_done", {4'b0, done}, 5'd0);
    check("mid_rst_D", D, 5'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("mid_rst_nodone", 5'(pulses), 5'd0);
    #2 rst_n = 1'b1;
    run_op(4'b1111, 4'b1111, 1'b0, 5'b00000, "post_rst");

    // Exhaustive sweep of all 512 combinations
    for (int i = 0; i < 512; i++)
      run_op(4'(i >> 5), 4'(i >> 1), 1'(i), ref_sub((i >> 5) & 15, (i >> 1) & 15, i & 1), "exh");

    // Random load/operand traffic, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      load = 1'($urandom_range(0, 2) == 0);
      a = 4'($urandom); b = 4'($urandom); Bin = 1'($urandom);
    end
    @(posedge clk); #2 load = 1'b0;
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbs_serial.md
RBS_SERIAL -- requirements
Module: rbs_serial

Interface
REQ-001: The module SHALL have no parameters; the operand width is fixed at 4 bits.
REQ-002: clk  input  1  system clock; all state changes on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: load  input  1  start request; sampled on rising edge of clk.
REQ-005: a  input  4  minuend, unsigned.
REQ-006: b  input  4  subtrahend, unsigned.
REQ-007: Bin  input  1  borrow-in.
REQ-008: busy  output  1  high while a subtraction is in progress.
REQ-009: done  output  1  one-cycle pulse marking a new valid D.
REQ-010: D  output  5  result: D[3:0] = difference, D[4] = borrow-out.
REQ-011: The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012: The block SHALL be a bit-serial ripple-borrow subtractor with three states: IDLE, SHIFT and DONE.
REQ-013: In IDLE or DONE, load=1 at a rising edge SHALL capture a, b and Bin into internal registers, clear the bit counter, and enter SHIFT.
REQ-014: load SHALL be ignored while in SHIFT; captured operands SHALL NOT change until the operation completes.
REQ-015: In SHIFT, each edge SHALL process one bit, LSB first:
  - diff bit = a_i ^ b_i ^ brw
  - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw)
  - brw is initialised from Bin.
REQ-016: The counter SHALL increment on every SHIFT edge. On the edge that processes bit 3, D SHALL be loaded with {brw_next, diff[3:0]}, and the state SHALL go to DONE.
REQ-017: Latency: load sampled at edge N SHALL cause done=1 and a new D during the cycle following edge N+4.
REQ-018: busy SHALL be 1 exactly while the state is SHIFT (4 cycles per operation).
REQ-019: done SHALL be 1 exactly while the state is DONE (one cycle).
REQ-020: From DONE, the next edge SHALL go to SHIFT if load=1; otherwise it SHALL go to IDLE.
REQ-021: D SHALL hold its last result until the next completion; it SHALL NOT change during SHIFT.
REQ-022: Arithmetic, for all 512 input combinations:
  - D[3:0] SHALL equal (a - b - Bin) mod 16.
  - D[4] SHALL be 1 iff a < b + Bin (unsigned).
REQ-023: Any value of a, b or Bin that changes after the load edge SHALL NOT affect the result in progress.

Reset
REQ-024: rst_n=0 SHALL immediately force the following, independent of clk:
  - state = IDLE
  - busy = 0, done = 0, D = 5'b00000
  - counter, operand registers and borrow register = 0
REQ-025: Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; D SHALL read 0.
REQ-026: After rst_n deasserts, the first rising edge with load=1 SHALL start a new operation normally.

Verification
REQ-027: Basic borrow case: a=4'b0001, b=4'b0101, Bin=0, load one cycle -> busy for 4 cycles, then done=1 for one cycle with D=5'b11100.
REQ-028: Back-to-back operations with load held high through DONE:
  - a=4'b0111, b=4'b0111, Bin=0 -> D=5'b00000.
  - Next: a=4'b1000, b=4'b0111, Bin=1 -> D=5'b00000, with no IDLE cycle between the two operations.
REQ-029: Borrow-in underflow and no-borrow case:
  - a=4'b0000, b=4'b0000, Bin=1 -> D=5'b11111.
  - a=4'b1100, b=4'b0100, Bin=0 -> D=5'b01000.
REQ-030: Load during SHIFT: start a=4'b1001, b=4'b1010, Bin=1; pulse load again with a=4'b1111, b=4'b0000 on cycle 2 -> second load ignored; D=5'b11110, single done pulse.
REQ-031: Reset mid-operation: assert rst_n=0 during cycle 2 of SHIFT -> busy, done and D are 0 immediately, with no done pulse. After release, a=4'b1111, b=4'b1111, Bin=0 -> D=5'b00000.
REQ-032: Exhaustive check: all 512 combinations of (a, b, Bin) SHALL be compared against a reference model, checking both D and the 4-cycle latency.
